// File: rtl/yf_prog_loader.sv
// yf_prog_loader: receives a framed program image as a byte stream, assembles
// 16-bit instruction words and writes them into IMEM from address 0. The core
// is held in reset until a frame with a matching XOR checksum has been loaded.
//
// state | meaning
// IDLE  | waiting for SYNC, nothing loaded since reset
// CNT_H | expecting word count MSB
// CNT_L | expecting word count LSB, range-checked on acceptance
// W_HI  | expecting high byte of the next word
// W_LO  | expecting low byte of the next word
// WRITE | one-cycle IMEM write strobe, input stalled
// CHK   | expecting checksum byte
// DONE  | frame verified, core released; waiting for next SYNC
// ERROR | length or checksum error, core held; waiting for next SYNC
module yf_prog_loader #(
  parameter int          im_size = 16,
  parameter int          iw_size = 16,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [im_size-1:0] imem_addr,
  output logic [iw_size-1:0] imem_wdata,
  output logic               cpu_rst,
  output logic               busy,
  output logic               done,
  output logic               err_chk,
  output logic               err_len,
  output logic [15:0]        words_out
);

  typedef enum logic [3:0] {
    IDLE, CNT_H, CNT_L, W_HI, W_LO, WRITE, CHK, DONE, ERROR
  } state_t;

  // Largest legal word count; 17 bits so the default depth of 65536 fits.
  localparam logic [16:0] MAX_WORDS = 17'(1) << im_size;

  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [15:0]          words_q, words_d;
  logic [im_size-1:0]   addr_q, addr_d;
  logic [7:0]           hi_q, hi_d;
  logic [7:0]           lo_q, lo_d;
  logic [7:0]           acc_q, acc_d;
  logic                 rdy_q, rdy_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_chk_q, err_chk_d;
  logic                 err_len_q, err_len_d;
  logic                 byte_ok;
  logic [16:0]          cnt_full;

  assign byte_ok  = rx_valid && rdy_q;
  assign cnt_full = {1'b0, cnt_q[15:8], rx_data};

  // Next-state and register updates for the frame parser.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    words_d   = words_q;
    addr_d    = addr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    cpu_rst_d = cpu_rst_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_chk_d = err_chk_q;
    err_len_d = err_len_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (byte_ok && rx_data == SYNC) begin
          state_d   = CNT_H;
          busy_d    = 1'b1;
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
          err_chk_d = 1'b0;
          err_len_d = 1'b0;
          words_d   = '0;
          acc_d     = '0;
          addr_d    = '0;
        end
      end
      CNT_H: begin
        if (byte_ok) begin
          cnt_d[15:8] = rx_data;
          state_d     = CNT_L;
        end
      end
      CNT_L: begin
        if (byte_ok) begin
          cnt_d = cnt_full[15:0];
          if (cnt_full > MAX_WORDS) begin
            state_d   = ERROR;
            err_len_d = 1'b1;
            busy_d    = 1'b0;
          end else if (cnt_full == 17'd0) begin
            state_d = CHK;
          end else begin
            state_d = W_HI;
          end
        end
      end
      W_HI: begin
        if (byte_ok) begin
          hi_d    = rx_data;
          acc_d   = acc_q ^ rx_data;
          state_d = W_LO;
        end
      end
      W_LO: begin
        if (byte_ok) begin
          lo_d    = rx_data;
          acc_d   = acc_q ^ rx_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        words_d = words_q + 16'd1;
        if (words_q + 16'd1 == cnt_q) begin
          state_d = CHK;
        end else begin
          state_d = W_HI;
          addr_d  = addr_q + im_size'(1);
        end
      end
      CHK: begin
        if (byte_ok) begin
          busy_d = 1'b0;
          if (rx_data == acc_q) begin
            state_d   = DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d   = ERROR;
            err_chk_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Ready is registered so it drops for exactly the WRITE cycle.
    rdy_d = (state_d != WRITE);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      words_q   <= '0;
      addr_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      rdy_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      words_q   <= words_d;
      addr_q    <= addr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      rdy_q     <= rdy_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
    end
  end

  assign rx_ready   = rdy_q;
  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = iw_size'({hi_q, lo_q});
  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_chk    = err_chk_q;
  assign err_len    = err_len_q;
  assign words_out  = words_q;

endmodule

// File: tb/tb_yf_prog_loader.sv
// Directed bench for yf_prog_loader, built with a 16-word IMEM (im_size=4)
// so the length limit and the full-depth boundary are reachable.
module tb_yf_prog_loader;

  localparam int IM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [IM-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err_chk;
  logic          err_len;
  logic [15:0]   words_out;

  int checks   = 0;
  int failures = 0;

  typedef logic [7:0] byte_q_t[$];

  logic [IM-1:0] wr_addr[$];
  logic [15:0]   wr_data[$];
  logic          cnt_en = 1'b0;
  logic          prev_low = 1'b0;
  int            low_cnt = 0;
  int            dbl_low = 0;

  yf_prog_loader #(.im_size(IM), .iw_size(16), .SYNC(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .err_chk(err_chk), .err_len(err_len), .words_out(words_out)
  );

  always #5 clk = ~clk;

  // Record every IMEM write strobe.
  always @(posedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  // Count ready-low cycles and back-to-back low cycles while enabled.
  always @(negedge clk) begin
    if (cnt_en) begin
      if (!rx_ready) begin
        low_cnt++;
        if (prev_low) dbl_low++;
      end
      prev_low <= !rx_ready;
    end else begin
      prev_low <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input byte_q_t f, input bit gaps);
    for (int i = 0; i < f.size(); i++) send(f[i], gaps ? (i % 6) : 0);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Checks the two writes produced by the reference frame 12 40 41 23.
  task automatic chk_ref_writes(input string tag);
    chk({tag, "_nwr"}, wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      chk({tag, "_a0"}, 32'(wr_addr[0]), 0);
      chk({tag, "_d0"}, 32'(wr_data[0]), 32'h1240);
      chk({tag, "_a1"}, 32'(wr_addr[1]), 1);
      chk({tag, "_d1"}, 32'(wr_data[1]), 32'h4123);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 1);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 0);
    chk({tag, "_imem_we"}, 32'(imem_we), 0);
    chk({tag, "_addr"}, 32'(imem_addr), 0);
    chk({tag, "_wdata"}, 32'(imem_wdata), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, {err_chk, err_len}, 0);
    chk({tag, "_words"}, 32'(words_out), 0);
  endtask

  // XOR of 12,40,41,23 is 0x30.
  byte_q_t good_frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h40, 8'h41, 8'h23, 8'h30};

  initial begin
    byte_q_t f;
    logic [7:0] acc;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst0");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst0_ready_after", 32'(rx_ready), 1);

    // 1: valid frame, byte by byte with mid-frame status checks
    clear_log();
    send(8'hA5, 0);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_cpu_rst", 32'(cpu_rst), 1);
    send(8'h00, 0); send(8'h02, 0); send(8'h12, 0); send(8'h40, 0);
    send(8'h41, 0); send(8'h23, 0);
    chk("t1_we_lat", 32'(imem_we), 1);
    chk("t1_we_addr", 32'(imem_addr), 1);
    chk("t1_we_data", 32'(imem_wdata), 32'h4123);
    chk("t1_ready_low", 32'(rx_ready), 0);
    send(8'h30, 0);
    chk("t1_done", 32'(done), 1);
    chk("t1_cpu_rst_rel", 32'(cpu_rst), 0);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_err_chk", 32'(err_chk), 0);
    chk("t1_words", 32'(words_out), 2);
    idle();
    chk_ref_writes("t1");

    // 2: same frame, bad checksum
    clear_log();
    send(8'hA5, 0);
    chk("t2_done_clr", 32'(done), 0);
    chk("t2_cpu_rst_set", 32'(cpu_rst), 1);
    f = '{8'h00, 8'h02, 8'h12, 8'h40, 8'h41, 8'h23, 8'h31};
    send_frame(f, 1'b0);
    chk("t2_err_chk", 32'(err_chk), 1);
    chk("t2_done", 32'(done), 0);
    chk("t2_cpu_rst", 32'(cpu_rst), 1);
    chk("t2_words", 32'(words_out), 2);
    idle();
    chk_ref_writes("t2");

    // 3: count 17 exceeds 16-word IMEM, then empty frame
    clear_log();
    f = '{8'hA5, 8'h00, 8'h11};
    send_frame(f, 1'b0);
    idle();
    chk("t3_err_len", 32'(err_len), 1);
    chk("t3_err_chk_clr", 32'(err_chk), 0);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_cpu_rst", 32'(cpu_rst), 1);
    chk("t3_nwr", wr_addr.size(), 0);
    send(8'hA5, 0);
    chk("t3_err_len_clr", 32'(err_len), 0);
    f = '{8'h00, 8'h00, 8'h00};
    send_frame(f, 1'b0);
    idle();
    chk("t3_empty_done", 32'(done), 1);
    chk("t3_empty_cpu_rst", 32'(cpu_rst), 0);
    chk("t3_empty_words", 32'(words_out), 0);
    chk("t3_empty_nwr", wr_addr.size(), 0);

    // 3b: exactly 16 words fills the IMEM
    clear_log();
    f = '{8'hA5, 8'h00, 8'h10};
    acc = 8'h00;
    for (int i = 0; i < 16; i++) begin
      f.push_back(8'(i) | 8'h30);
      f.push_back(8'(i * 3) ^ 8'hC5);
      acc = acc ^ (8'(i) | 8'h30) ^ (8'(i * 3) ^ 8'hC5);
    end
    f.push_back(acc);
    send_frame(f, 1'b0);
    idle();
    chk("t3b_done", 32'(done), 1);
    chk("t3b_err_len", 32'(err_len), 0);
    chk("t3b_words", 32'(words_out), 16);
    chk("t3b_nwr", wr_addr.size(), 16);
    if (wr_addr.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("t3b_a%0d", i), 32'(wr_addr[i]), i);
        chk($sformatf("t3b_d%0d", i), 32'(wr_data[i]),
            {16'h0, 8'(i) | 8'h30, 8'(i * 3) ^ 8'hC5});
      end
    end

    // 4: garbage before SYNC and valid gaps of 0-5 cycles
    clear_log();
    f = '{8'h00, 8'hFF, 8'h5A};
    send_frame(f, 1'b1);
    chk("t4_garbage_done", 32'(done), 1);
    chk("t4_garbage_busy", 32'(busy), 0);
    send_frame(good_frame, 1'b1);
    idle();
    chk("t4_done", 32'(done), 1);
    chk("t4_cpu_rst", 32'(cpu_rst), 0);
    chk_ref_writes("t4");

    // 5: reset after third word byte, then a full frame
    clear_log();
    f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h40, 8'h41};
    send_frame(f, 1'b0);
    rst = 1'b1; rx_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("t5_rst");
    chk("t5_partial_nwr", wr_addr.size(), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_log();
    send_frame(good_frame, 1'b0);
    idle();
    chk("t5_done", 32'(done), 1);
    chk("t5_cpu_rst", 32'(cpu_rst), 0);
    chk_ref_writes("t5");

    // 6: rx_valid held high for the whole frame
    clear_log();
    low_cnt = 0; dbl_low = 0;
    cnt_en = 1'b1;
    send_frame(good_frame, 1'b0);
    @(negedge clk);
    cnt_en = 1'b0;
    idle();
    chk("t6_ready_lows", low_cnt, 2);
    chk("t6_ready_dbl", dbl_low, 0);
    chk("t6_done", 32'(done), 1);
    chk_ref_writes("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
